dem_recombine_checker: RTL and testbench

//  Receive-side counterpart of the 2-layer DEM switching tree.
//  - Takes the four layer-2 branch outputs and sums them back into one code, as the

---
 rtl/dem_recombine_checker.sv | 118 +++++++++++
 tb/tb_dem_recombine_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dem_recombine_checker.sv
// dem_recombine_checker: sums the four DEM branch outputs, checks them against the delayed tree input
// and keeps cumulative and per-window mismatch statistics.
module dem_recombine_checker #(
  parameter int INPUT_WIDTH = 16,
  parameter int REF_DELAY   = 2,
  parameter int TOL         = 2,
  parameter int WINDOW      = 256,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          clear_i,
  input  logic                          valid_i,
  input  logic signed [INPUT_WIDTH-1:0] x_in_i,
  input  logic signed [INPUT_WIDTH-1:0] x_out2_1_i,
  input  logic signed [INPUT_WIDTH-1:0] x_out2_2_i,
  input  logic signed [INPUT_WIDTH-1:0] x_out2_3_i,
  input  logic signed [INPUT_WIDTH-1:0] x_out2_4_i,
  output logic signed [INPUT_WIDTH+1:0] x_sum_o,
  output logic                          sum_valid_o,
  output logic                          mismatch_o,
  output logic                          err_sticky_o,
  output logic [CNT_WIDTH-1:0]          err_count_o,
  output logic                          window_done_o,
  output logic [CNT_WIDTH-1:0]          window_err_o
);
  localparam int SW = INPUT_WIDTH + 2;
  localparam int DW = INPUT_WIDTH + 3;
  localparam int WW = $clog2(WINDOW);
  localparam logic signed [DW-1:0] TOL_S = DW'(TOL);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  typedef enum logic {IDLE, RUN} state_t;
  logic                          vld_q [REF_DELAY];
  logic signed [INPUT_WIDTH-1:0] ref_q [REF_DELAY];
  logic signed [SW-1:0]          sum_d, x_sum_q;
  logic signed [DW-1:0]          diff_d;
  logic                          sv_d, mis_d, sum_valid_q, mismatch_q, sticky_q, done_q;
  logic [CNT_WIDTH-1:0]          err_cnt_q, err_cnt_d, acc_q, acc_d, win_err_q;
  logic [WW-1:0]                 win_cnt_q;
  state_t                        state_q;

  // Four sign-extended branches fit in INPUT_WIDTH+2 bits, so the sum cannot overflow.
  always_comb begin
    sv_d      = vld_q[REF_DELAY-1];
    sum_d     = SW'(x_out2_1_i) + SW'(x_out2_2_i) + SW'(x_out2_3_i) + SW'(x_out2_4_i);
    diff_d    = DW'(sum_d) - DW'(ref_q[REF_DELAY-1]);
    mis_d     = sv_d && (diff_d > TOL_S || diff_d < -TOL_S);
    err_cnt_d = err_cnt_q + CNT_WIDTH'(mis_d && err_cnt_q != '1);
    acc_d     = acc_q + CNT_WIDTH'(mis_d && acc_q != '1);
  end

  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < REF_DELAY; i++) begin
        vld_q[i] <= 1'b0;
        ref_q[i] <= '0;
      end
      x_sum_q     <= '0;
      sum_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      vld_q[0] <= valid_i;
      ref_q[0] <= x_in_i;
      for (int i = 1; i < REF_DELAY; i++) begin
        vld_q[i] <= vld_q[i-1];
        ref_q[i] <= ref_q[i-1];
      end
      x_sum_q     <= sv_d ? sum_d : x_sum_q;
      sum_valid_q <= sv_d;
      mismatch_q  <= mis_d;
    end

  // Window counter is zero whenever the FSM is IDLE, so the first valid sum is sample 1 of the window.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      acc_q     <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
      win_err_q <= '0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      acc_q     <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
      win_err_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mis_d) begin
        err_cnt_q <= err_cnt_d;
        sticky_q  <= 1'b1;
      end
      if (sv_d) begin
        state_q <= RUN;
        if (state_q == RUN && win_cnt_q == WIN_LAST) begin
          done_q    <= 1'b1;
          win_err_q <= acc_d;
          acc_q     <= '0;
          win_cnt_q <= '0;
        end else begin
          acc_q     <= acc_d;
          win_cnt_q <= win_cnt_q + 1'b1;
        end
      end
    end

  assign x_sum_o       = x_sum_q;
  assign sum_valid_o   = sum_valid_q;
  assign mismatch_o    = mismatch_q;
  assign err_sticky_o  = sticky_q;
  assign err_count_o   = err_cnt_q;
  assign window_done_o = done_q;
  assign window_err_o  = win_err_q;
endmodule

// File: tb/tb_dem_recombine_checker.sv
// tb_dem_recombine_checker: directed and random stimulus against a per-cycle behavioural model.
module tb_dem_recombine_checker;
  localparam int IW = 16, RD = 2, TOL = 2, WIN = 8, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk_i = 1'b0, reset_i = 1'b1, clear_i = 1'b0, valid_i = 1'b0;
  logic signed [IW-1:0] x_in_i = '0, b1 = '0, b2 = '0, b3 = '0, b4 = '0;
  logic signed [IW+1:0] x_sum_o;
  logic sum_valid_o, mismatch_o, err_sticky_o, window_done_o;
  logic [CW-1:0] err_count_o, window_err_o;
  int n_chk = 0, n_fail = 0;
  int e_sum, e_sv, e_mis, e_st, e_cnt, e_done, e_werr, wc, acc;
  bit mq_v[$];
  int mq_x[$];
  bit pq_v[$];
  int pq_x[$], pq_e[$];

  dem_recombine_checker #(.INPUT_WIDTH(IW), .REF_DELAY(RD), .TOL(TOL), .WINDOW(WIN), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .valid_i(valid_i), .x_in_i(x_in_i),
    .x_out2_1_i(b1), .x_out2_2_i(b2), .x_out2_3_i(b3), .x_out2_4_i(b4),
    .x_sum_o(x_sum_o), .sum_valid_o(sum_valid_o), .mismatch_o(mismatch_o), .err_sticky_o(err_sticky_o),
    .err_count_o(err_count_o), .window_done_o(window_done_o), .window_err_o(window_err_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic signed [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic mreset();
    {e_sum, e_sv, e_mis, e_st, e_cnt, e_done, e_werr, wc, acc} = '0;
    mq_v.delete();
    mq_x.delete();
    for (int i = 0; i < RD; i++) begin
      mq_v.push_back(1'b0);
      mq_x.push_back(0);
    end
  endtask

  task automatic cmp_all();
    chk("x_sum", x_sum_o, e_sum);
    chk("sum_valid", sum_valid_o, e_sv);
    chk("mismatch", mismatch_o, e_mis);
    chk("sticky", err_sticky_o, e_st);
    chk("err_count", err_count_o, e_cnt);
    chk("window_done", window_done_o, e_done);
    chk("window_err", window_err_o, e_werr);
  endtask

  // One clock: the model consumes the inputs held across the edge, then every output is compared.
  task automatic step();
    bit hv;
    int hx, s, d, mis;
    @(posedge clk_i);
    hv = mq_v.pop_front();
    hx = mq_x.pop_front();
    mq_v.push_back(valid_i);
    mq_x.push_back(int'(x_in_i));
    s = int'(b1) + int'(b2) + int'(b3) + int'(b4);
    d = s - hx;
    mis = (hv && (d > TOL || d < -TOL)) ? 1 : 0;
    if (hv) e_sum = s;
    e_sv = hv;
    e_mis = mis;
    if (clear_i) {e_cnt, e_st, e_werr, wc, acc, e_done} = '0;
    else begin
      e_done = 0;
      if (mis != 0) begin
        e_cnt = (e_cnt < CMAX) ? e_cnt + 1 : CMAX;
        e_st = 1;
      end
      if (hv) begin
        acc = (acc + mis > CMAX) ? CMAX : acc + mis;
        wc++;
        if (wc == WIN) begin
          e_done = 1;
          e_werr = acc;
          acc = 0;
          wc = 0;
        end
      end
    end
    #1;
    cmp_all();
  endtask

  // Present one sample and explicit branches RD clocks later.
  task automatic pair(input int x, input int c1, input int c2, input int c3, input int c4);
    valid_i = 1'b1;
    x_in_i = IW'(x);
    step();
    valid_i = 1'b0;
    for (int i = 1; i < RD; i++) step();
    b1 = IW'(c1); b2 = IW'(c2); b3 = IW'(c3); b4 = IW'(c4);
    step();
  endtask

  // Streaming driver: branches for the sample queued RD cycles ago, split evenly with error e on branch 4.
  task automatic cyc(input bit v, input int x, input int e);
    int px, pe, bb;
    pq_v.push_back(v);
    pq_x.push_back(x);
    pq_e.push_back(e);
    px = 0;
    pe = 0;
    if (pq_x.size() > RD) begin
      void'(pq_v.pop_front());
      px = pq_x.pop_front();
      pe = pq_e.pop_front();
    end
    bb = px >>> 2;
    b1 = IW'(bb); b2 = IW'(bb); b3 = IW'(bb);
    b4 = IW'(px - 3 * bb + pe);
    valid_i = v;
    x_in_i = IW'(x);
    step();
  endtask

  initial begin
    int r, x, e;
    mreset();
    #1;
    cmp_all();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    pair(20000, 5000, 5000, 5000, 5000);
    chk("t1 sum", x_sum_o, 20000);
    chk("t1 mis", mismatch_o, 0);
    pair(20000, 5000, 5000, 5000, 5004);
    chk("t2 mis", mismatch_o, 1);
    chk("t2 cnt", err_count_o, 1);
    chk("t2 sticky", err_sticky_o, 1);
    pair(20000, 5000, 5000, 5000, 4998);
    chk("t2 tol edge", mismatch_o, 0);
    pair(-20000, -5000, -5000, -5000, -5001);
    chk("t3 neg sum", x_sum_o, -20001);
    chk("t3 neg mis", mismatch_o, 0);
    pair(-32768, -32768, -32768, -32768, -32768);
    chk("t3 extreme", x_sum_o, -131072);
    clear_i = 1'b1;
    cyc(0, 0, 0);
    clear_i = 1'b0;
    for (int i = 0; i < WIN; i++) cyc(1, 1000 * i - 3000, (i == 1 || i == 4 || i == 6) ? 5 : 0);
    for (int i = 0; i < RD; i++) cyc(0, 0, 0);
    chk("t4 done", window_done_o, 1);
    chk("t4 werr", window_err_o, 3);
    for (int i = 0; i < WIN; i++) cyc(1, 777 * i, 0);
    for (int i = 0; i < RD; i++) cyc(0, 0, 0);
    chk("t4 done2", window_done_o, 1);
    chk("t4 werr2", window_err_o, 0);
    for (int i = 0; i < 20; i++) cyc(1, 100 * i, 7);
    for (int i = 0; i < RD; i++) cyc(0, 0, 0);
    chk("t5 sat", err_count_o, 15);
    cyc(1, 500, 7);
    for (int i = 1; i < RD; i++) cyc(0, 0, 0);
    clear_i = 1'b1;
    cyc(0, 0, 0);
    clear_i = 1'b0;
    chk("t5 clr mis", mismatch_o, 1);
    chk("t5 clr cnt", err_count_o, 0);
    chk("t5 clr sticky", err_sticky_o, 0);
    for (int i = 0; i < 3; i++) cyc(1, 4000 + i, i);
    #2 reset_i = 1'b1;
    #1;
    mreset();
    cmp_all();
    valid_i = 1'b0;
    pq_v.delete();
    pq_x.delete();
    pq_e.delete();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    cyc(1, 1000, 0);
    for (int i = 0; i < RD; i++) cyc(0, 0, 0);
    chk("t6 sum", x_sum_o, 1000);
    chk("t6 valid", sum_valid_o, 1);
    for (int n = 0; n < 400; n++) begin
      clear_i = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      e = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 200)) - 100;
      x = int'($urandom_range(0, 65535)) - 32768;
      cyc($urandom_range(0, 9) < 7, x, e);
    end
    clear_i = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
